// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
package fifo_pkg;

   // Accumulator state: FILL while lanes remain, HOLD while a full word waits on a busy output.
   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } packer_state_e;

   // Lane counter width; the count must reach ratio itself (the HOLD value), hence ratio + 1.
   function automatic int cnt_w(input int ratio);
      return $clog2(ratio + 1);
   endfunction

endpackage

// File: rtl/fifo_packer_out_reg.sv
// Valid/ready output register: loads a new word, holds it until accepted, then drops valid.
module fifo_packer_out_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             m_ready,
   output logic             can_load,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // Next state: a load replaces the word (even on the accept edge), an accept alone clears valid.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (valid_q && m_ready) begin
         valid_d = 1'b0;
      end
   end

   // Output register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values, like real hardware.
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign can_load = !valid_q || m_ready;
   assign m_valid  = valid_q;
   assign m_data   = data_q;

endmodule

// File: rtl/fifo_word_packer.sv
// Pops narrow words from sync_fifo and packs PACK_RATIO of them into one wide valid/ready word.
// First-popped word lands in the least significant lane.
// Optional feature macro: FIFO_PACKER_FLUSH_EN adds a flush input and a per-lane m_keep output
// so a partial word can be forced out.
module fifo_word_packer
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_RATIO = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic                             rd_en,
   input  logic [DATA_WIDTH-1:0]            rd_data,
   input  logic                             empty,
`ifdef FIFO_PACKER_FLUSH_EN
   input  logic                             flush,
   output logic [PACK_RATIO-1:0]            m_keep,
`endif
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data
);

   localparam int              CNT_W    = cnt_w(PACK_RATIO);
   localparam int              WIDE_W   = DATA_WIDTH * PACK_RATIO;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_RATIO);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACK_RATIO - 1);
`ifdef FIFO_PACKER_FLUSH_EN
   localparam int              OUT_W    = WIDE_W + PACK_RATIO;
`else
   localparam int              OUT_W    = WIDE_W;
`endif

   packer_state_e     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              inflight_q, inflight_d;
   logic [WIDE_W-1:0] acc_q, acc_d;
   logic [WIDE_W-1:0] move_data;
   logic              move;
   logic              out_can_load;
   logic              pop_block;
   logic [OUT_W-1:0]  out_load_data;
   logic [OUT_W-1:0]  out_data;
`ifdef FIFO_PACKER_FLUSH_EN
   logic              flush_pend_q, flush_pend_d;
   logic [PACK_RATIO-1:0] move_keep;
`endif

   // Capture, completion/move decisions, accumulator FSM and pop issue.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      move      = 1'b0;
`ifdef FIFO_PACKER_FLUSH_EN
      move_keep = '1;
`endif
      unique case (state_q)
         FILL: begin
            if (inflight_q) begin
               acc_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = rd_data;
               if (cnt_q == LAST_CNT) begin
                  if (out_can_load) begin
                     move  = 1'b1;
                     cnt_d = '0;
                  end else begin
                     cnt_d   = FULL_CNT;
                     state_d = HOLD;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
`ifdef FIFO_PACKER_FLUSH_EN
            else if (flush_pend_q && (cnt_q != '0) && out_can_load) begin
               move  = 1'b1;
               cnt_d = '0;
               for (int i = 0; i < PACK_RATIO; i++) begin
                  move_keep[i] = (CNT_W'(i) < cnt_q);
               end
            end
`endif
         end
         HOLD: begin
            if (out_can_load) begin
               move    = 1'b1;
               cnt_d   = '0;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase

      // The moved word includes this edge's capture; the cleared accumulator keeps unfilled lanes zero.
      move_data = acc_d;
      if (move) begin
         acc_d = '0;
      end

      // Pop when the lane the data will land in after this edge exists; a completing move frees
      // lane 0 on the same edge, which keeps the stream at one word per clock.
      rd_en = !empty && !rst && (cnt_d < FULL_CNT) && !pop_block;
   end

   assign inflight_d = rd_en;

`ifdef FIFO_PACKER_FLUSH_EN
   // Flush request: blocks pops until any in-flight word lands, then emits or discards the partial.
   always_comb begin
      flush_pend_d = flush_pend_q;
      if (flush_pend_q && !inflight_q && ((cnt_q == '0) || move)) begin
         flush_pend_d = 1'b0;
      end
      if (flush) begin
         flush_pend_d = 1'b1;
      end
   end

   assign pop_block     = flush_pend_q || flush;
   assign out_load_data = {move_keep, move_data};
   assign m_keep        = out_data[WIDE_W +: PACK_RATIO];
`else
   assign pop_block     = 1'b0;
   assign out_load_data = move_data;
`endif

   assign m_data = out_data[WIDE_W-1:0];

   // Accumulator, lane count, pop tracking and state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FILL;
         cnt_q        <= '0;
         inflight_q   <= 1'b0;
         // NOTE: the accumulator is reset on purpose; flushed partial words rely on unfilled lanes being zero.
         acc_q        <= '0;
`ifdef FIFO_PACKER_FLUSH_EN
         flush_pend_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         inflight_q   <= inflight_d;
         acc_q        <= acc_d;
`ifdef FIFO_PACKER_FLUSH_EN
         flush_pend_q <= flush_pend_d;
`endif
      end
   end

   fifo_packer_out_reg #(
      .WIDTH (OUT_W)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (move),
      .load_data (out_load_data),
      .m_ready   (m_ready),
      .can_load  (out_can_load),
      .m_valid   (m_valid),
      .m_data    (out_data)
   );

endmodule
